// File: rtl/conv_mac_pipe_pkg.sv
// Shared defaults and helpers for the KxK convolution MAC pipeline.
package conv_mac_pipe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 25;
  localparam int DEF_K      = 4;
  localparam int DEF_MAX_CH = 64;

  // LSB of window element (r,c) in a packed K*K*W vector.
  function automatic int elem_lsb(input int r, input int c, input int k, input int w);
    return (r * k + c) * w;
  endfunction

  // Internal sum width: wide enough that one beat's full K*K sum plus the
  // accumulator never overflows before the clamp/wrap decision, even when
  // ACC_W is configured narrower than a single beat's dynamic range.
  function automatic int wide_w(input int acc_w, input int data_w, input int k);
    return acc_w + 2 * data_w + $clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Beat/result bus of the convolution MAC engine.
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1; the source holds valid and its payload stable until that edge, and
// valid never depends combinationally on ready.
interface conv_mac_pipe_if import conv_mac_pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K      = DEF_K,
  parameter int CH_W   = $clog2(DEF_MAX_CH)
) ();

  logic [CH_W-1:0]          cfg_ch_num;
  logic                     cfg_sat_en;
  logic                     in_valid;
  logic                     in_ready;
  logic [K*K*DATA_W-1:0]    in_data;
  logic [K*K*DATA_W-1:0]    in_kernel;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_result;
  logic                     out_sat;
  logic [CH_W-1:0]          ch_cnt;

  modport master (
    output cfg_ch_num, cfg_sat_en, in_valid, in_data, in_kernel, out_ready,
    input  in_ready, out_valid, out_result, out_sat, ch_cnt
  );

  modport slave (
    input  cfg_ch_num, cfg_sat_en, in_valid, in_data, in_kernel, out_ready,
    output in_ready, out_valid, out_result, out_sat, ch_cnt
  );

endinterface

// File: rtl/conv_mac_pipe_row_dot.sv
// One window row: K signed products (registered by the caller in S1) and
// the adder tree over those registered products (registered in S2).
module conv_mac_pipe_row_dot #(
  parameter int DATA_W = 8,
  parameter int K      = 4,
  parameter int SUM_W  = 46
) (
  input  logic [K*DATA_W-1:0]   data,
  input  logic [K*DATA_W-1:0]   kern,
  output logic [K*2*DATA_W-1:0] prod,
  input  logic [K*2*DATA_W-1:0] prod_q,
  output logic signed [SUM_W-1:0] row_sum
);

  localparam int PW = 2 * DATA_W;

  // Signed element-wise products of this row.
  always_comb begin
    prod = '0;
    for (int c = 0; c < K; c++) begin
      prod[c*PW +: PW] = PW'(signed'(data[c*DATA_W +: DATA_W])) *
                         PW'(signed'(kern[c*DATA_W +: DATA_W]));
    end
  end

  // Sign-extended sum of the registered products.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < K; c++) begin
      row_sum = row_sum + SUM_W'(signed'(prod_q[c*PW +: PW]));
    end
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined KxK convolution MAC: S1 products, S2 row sums, S3 channel
// accumulation with optional saturation, then a held output register.
module conv_mac_pipe import conv_mac_pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K      = DEF_K,
  parameter int MAX_CH = DEF_MAX_CH,
  parameter int CH_W   = $clog2(MAX_CH)
) (
  input logic            clk,
  input logic            rst,
  conv_mac_pipe_if.slave bus
);

  localparam int PW     = 2 * DATA_W;
  localparam int NP     = K * K;
  localparam int WIDE_W = wide_w(ACC_W, DATA_W, K);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic             rdy_q;
  logic             stall;
  logic             in_ready_c;
  logic             accept;
  logic             first_beat;
  logic             last_beat;
  logic [CH_W-1:0]  ch_cnt;
  logic [CH_W-1:0]  ch_num_q;
  logic [CH_W-1:0]  ch_num_eff;

  logic [NP*PW-1:0] prod_c;
  logic [NP*PW-1:0] s1_prod;
  logic             s1_valid, s1_first, s1_last;

  logic signed [WIDE_W-1:0] row_c [K];
  logic signed [WIDE_W-1:0] row_q [K];
  logic             s2_valid, s2_first, s2_last;

  logic signed [WIDE_W-1:0] beat_sum;
  logic signed [WIDE_W-1:0] base;
  logic signed [WIDE_W-1:0] wide;
  logic [ACC_W-1:0] acc, acc_n;
  logic             sat_flag, flag_n, sat_hit;
  logic             s3_last;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_result_q;
  logic             out_sat_q;

  // The whole pipeline freezes only while a finished result waits for its consumer.
  assign stall      = out_valid_q & ~bus.out_ready;
  assign in_ready_c = rdy_q & ~stall;
  assign accept     = bus.in_valid & in_ready_c;

  // Channel 0 takes the live group size; later beats use the latched copy.
  assign first_beat = (ch_cnt == '0);
  assign ch_num_eff = first_beat ? bus.cfg_ch_num : ch_num_q;
  assign last_beat  = (ch_cnt == ch_num_eff);

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.ch_cnt     = ch_cnt;

  for (genvar r = 0; r < K; r++) begin : g_row
    conv_mac_pipe_row_dot #(
      .DATA_W (DATA_W),
      .K      (K),
      .SUM_W  (WIDE_W)
    ) u_row (
      .data    (bus.in_data[elem_lsb(r, 0, K, DATA_W) +: K*DATA_W]),
      .kern    (bus.in_kernel[elem_lsb(r, 0, K, DATA_W) +: K*DATA_W]),
      .prod    (prod_c[r*K*PW +: K*PW]),
      .prod_q  (s1_prod[r*K*PW +: K*PW]),
      .row_sum (row_c[r])
    );
  end

  // in_ready comes up on the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // Channel counter and latched group size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt   <= '0;
      ch_num_q <= '0;
    end else if (accept) begin
      if (first_beat) ch_num_q <= bus.cfg_ch_num;
      ch_cnt <= last_beat ? '0 : ch_cnt + 1'b1;
    end
  end

  // S1: register the K*K products with group position tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_first <= first_beat;
      s1_last  <= last_beat;
      if (accept) s1_prod <= prod_c;
    end
  end

  // S2: register the K row sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      for (int r = 0; r < K; r++) row_q[r] <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      for (int r = 0; r < K; r++) row_q[r] <= row_c[r];
    end
  end

  // S3 combinational: beat total, load-or-add, then clamp or wrap.
  always_comb begin
    beat_sum = '0;
    for (int r = 0; r < K; r++) beat_sum = beat_sum + row_q[r];
    base    = s2_first ? '0 : {{(WIDE_W-ACC_W){acc[ACC_W-1]}}, acc};
    wide    = base + beat_sum;
    acc_n   = wide[ACC_W-1:0];
    sat_hit = 1'b0;
    if (bus.cfg_sat_en) begin
      if (wide > SAT_MAX) begin
        acc_n   = ACC_MAX;
        sat_hit = 1'b1;
      end else if (wide < SAT_MIN) begin
        acc_n   = ACC_MIN;
        sat_hit = 1'b1;
      end
    end
    flag_n = (s2_first ? 1'b0 : sat_flag) | sat_hit;
  end

  // S3: accumulator and sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sat_flag <= 1'b0;
      s3_last  <= 1'b0;
    end else if (!stall) begin
      s3_last <= s2_valid & s2_last;
      if (s2_valid) begin
        acc      <= acc_n;
        sat_flag <= flag_n;
      end
    end
  end

  // Output register: loads a finished group, holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s3_last;
      if (s3_last) begin
        out_result_q <= acc;
        out_sat_q    <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: default 25-bit accumulator instance plus
// a 16-bit instance for saturation/wrap behaviour.
module tb_conv_mac_pipe;

  localparam int DW  = 8;
  localparam int K   = 4;
  localparam int NP  = K * K;
  localparam int AW  = 25;
  localparam int AW2 = 16;
  localparam int CW  = 6;

  typedef logic [NP*DW-1:0] win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;

  logic [AW:0]  exp_q[$];
  logic [AW2:0] exp16_q[$];

  bit rec = 1'b0;
  int pop_n = 0;
  int pop_cyc[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW),  .K(K), .CH_W(CW)) bus_a ();
  conv_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW2), .K(K), .CH_W(CW)) bus_b ();

  conv_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .K(K), .MAX_CH(64), .CH_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  conv_mac_pipe #(.DATA_W(DW), .ACC_W(AW2), .K(K), .MAX_CH(64), .CH_W(CW)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic win_t fill(input int v);
    win_t w;
    for (int i = 0; i < NP; i++) w[i*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic longint dot(input win_t d, input win_t k);
    longint s = 0;
    for (int i = 0; i < NP; i++) begin
      longint a = longint'($signed(d[i*DW +: DW]));
      longint b = longint'($signed(k[i*DW +: DW]));
      s += a * b;
    end
    return s;
  endfunction

  // Reference accumulate step: clamp to w-bit signed range or wrap modulo 2^w.
  function automatic longint step(input longint prev, input longint beat, input bit sat_en,
                                  input int w, output bit hit);
    longint one = 1;
    longint maxv = (one << (w - 1)) - 1;
    longint minv = -maxv - 1;
    longint v = prev + beat;
    hit = 1'b0;
    if (sat_en) begin
      if (v > maxv) begin v = maxv; hit = 1'b1; end
      else if (v < minv) begin v = minv; hit = 1'b1; end
    end else begin
      v = v & ((one << w) - 1);
      if (v > maxv) v = v - (one << w);
    end
    return v;
  endfunction

  task automatic start_beat(input bit sel, input win_t d, input win_t k);
    if (sel) begin
      bus_b.in_valid = 1'b1; bus_b.in_data = d; bus_b.in_kernel = k;
    end else begin
      bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_kernel = k;
    end
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic wait_accept(input bit sel, input string tag);
    bit done = 1'b0;
    bit rdy;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      rdy = sel ? bus_b.in_ready : bus_a.in_ready;
      if (rdy) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    check({tag, "_accept"}, 64'(done), 64'(1));
  endtask

  task automatic send(input bit sel, input win_t d, input win_t k, input string tag);
    start_beat(sel, d, k);
    wait_accept(sel, tag);
    if (sel) bus_b.in_valid = 1'b0;
    else     bus_a.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 300 && (exp_q.size() != 0 || exp16_q.size() != 0); n++) @(posedge clk);
    #1;
    check({tag, "_drain"}, 64'(exp_q.size() + exp16_q.size()), 64'(0));
  endtask

  // Scoreboard: compare each consumed result against the head of its queue.
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      chk_cnt++;
      assert (exp_q.size() != 0) else begin
        err_cnt++;
        $error("FAIL unexpected_a: observed=%0h expected=none", {bus_a.out_sat, bus_a.out_result});
      end
      if (exp_q.size() != 0) begin
        logic [AW:0] e;
        e = exp_q.pop_front();
        check("result_a", 64'({bus_a.out_sat, bus_a.out_result}), 64'(e));
      end
      if (rec && pop_n < 16) pop_cyc[pop_n] = cyc;
      if (rec) pop_n++;
    end
    if (!rst && bus_b.out_valid && bus_b.out_ready) begin
      chk_cnt++;
      assert (exp16_q.size() != 0) else begin
        err_cnt++;
        $error("FAIL unexpected_b: observed=%0h expected=none", {bus_b.out_sat, bus_b.out_result});
      end
      if (exp16_q.size() != 0) begin
        logic [AW2:0] e;
        e = exp16_q.pop_front();
        check("result_b", 64'({bus_b.out_sat, bus_b.out_result}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sum, accm, beat;
    bit hit, flag;
    win_t d, k;
    logic [AW-1:0]  r25;
    logic [AW2-1:0] r16;

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_kernel = '0;
    bus_a.cfg_ch_num = '0; bus_a.cfg_sat_en = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_kernel = '0;
    bus_b.cfg_ch_num = '0; bus_b.cfg_sat_en = 1'b0; bus_b.out_ready = 1'b1;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready",   64'(bus_a.in_ready), 64'(0));
    check("rst_out_valid",  64'(bus_a.out_valid), 64'(0));
    check("rst_out_result", 64'(bus_a.out_result), 64'(0));
    check("rst_out_sat",    64'(bus_a.out_sat), 64'(0));
    check("rst_ch_cnt",     64'(bus_a.ch_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_held", 64'(bus_a.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready_pre", 64'(bus_a.in_ready), 64'(0));
    @(posedge clk); #1;
    check("rel_in_ready_post", 64'(bus_a.in_ready), 64'(1));

    // T1: single channel, latency 3
    bus_a.cfg_ch_num = 6'd0;
    exp_q.push_back({1'b0, 25'd16});
    send(1'b0, fill(1), fill(1), "t1");
    @(posedge clk); #1;
    check("t1_lat1", 64'(bus_a.out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_lat2", 64'(bus_a.out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_lat3", 64'(bus_a.out_valid), 64'(1));
    check("t1_value", 64'(bus_a.out_result), 64'(16));
    drain("t1");

    // T2: four channels, cfg change mid-group ignored
    bus_a.cfg_ch_num = 6'd3;
    sum = 0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("t2_ch_cnt%0d", n), 64'(bus_a.ch_cnt), 64'(n));
      d = fill(n + 1); k = fill(2);
      sum += dot(d, k);
      send(1'b0, d, k, "t2");
      if (n == 0) bus_a.cfg_ch_num = 6'd1;
    end
    check("t2_ch_cnt_wrap", 64'(bus_a.ch_cnt), 64'(0));
    check("t2_model", 64'(sum), 64'(320));
    r25 = AW'(sum);
    exp_q.push_back({1'b0, r25});
    drain("t2");

    // T3: 16-bit accumulator, saturate then wrap
    for (int pass = 0; pass < 2; pass++) begin
      bus_b.cfg_ch_num = 6'd7;
      bus_b.cfg_sat_en = (pass == 0);
      accm = 0; flag = 1'b0;
      for (int n = 0; n < 8; n++) begin
        beat = dot(fill(-128), fill(-128));
        accm = step((n == 0) ? 64'sd0 : accm, beat, (pass == 0), AW2, hit);
        flag |= hit;
        send(1'b1, fill(-128), fill(-128), "t3");
      end
      r16 = AW2'(accm);
      exp16_q.push_back({flag, r16});
      drain("t3");
    end

    // T4: backpressure with a third beat waiting
    bus_a.cfg_ch_num = 6'd0;
    bus_a.out_ready = 1'b0;
    r25 = AW'(dot(fill(3), fill(1)));  exp_q.push_back({1'b0, r25});
    send(1'b0, fill(3), fill(1), "t4a");
    r25 = AW'(dot(fill(-2), fill(5))); exp_q.push_back({1'b0, r25});
    send(1'b0, fill(-2), fill(5), "t4b");
    for (int n = 0; n < 20 && !bus_a.out_valid; n++) @(negedge clk);
    check("t4_valid", 64'(bus_a.out_valid), 64'(1));
    r25 = AW'(dot(fill(7), fill(-1))); exp_q.push_back({1'b0, r25});
    start_beat(1'b0, fill(7), fill(-1));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t4_in_ready", 64'(bus_a.in_ready), 64'(0));
      check("t4_hold", 64'({bus_a.out_valid, bus_a.out_result}), 64'({1'b1, 25'd48}));
    end
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    wait_accept(1'b0, "t4c");
    bus_a.in_valid = 1'b0;
    drain("t4");

    // T5: reset mid-group discards the partial sum
    bus_a.cfg_ch_num = 6'd3;
    send(1'b0, fill(9), fill(9), "t5p");
    send(1'b0, fill(9), fill(9), "t5p");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_ch_cnt", 64'(bus_a.ch_cnt), 64'(0));
    check("t5_rst_in_ready", 64'(bus_a.in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sum = 0;
    for (int n = 0; n < 4; n++) begin
      d = fill(1); k = fill(n + 1);
      sum += dot(d, k);
      send(1'b0, d, k, "t5");
    end
    r25 = AW'(sum);
    exp_q.push_back({1'b0, r25});
    drain("t5");

    // T6: streaming single-channel windows
    bus_a.cfg_ch_num = 6'd0;
    rec = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int e = 0; e < NP; e++) begin
        d[e*DW +: DW] = DW'($urandom_range(0, 255));
        k[e*DW +: DW] = DW'($urandom_range(0, 255));
      end
      r25 = AW'(dot(d, k));
      exp_q.push_back({1'b0, r25});
      start_beat(1'b0, d, k);
      wait_accept(1'b0, "t6");
    end
    bus_a.in_valid = 1'b0;
    drain("t6");
    rec = 1'b0;
    check("t6_count", 64'(pop_n), 64'(10));
    for (int j = 1; j < 10; j++)
      check($sformatf("t6_gap%0d", j), 64'(pop_cyc[j] - pop_cyc[j-1]), 64'(1));

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
